// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM
// states, instruction classes, ALU operation codes and mux-select values.
package rv32i_ctrl_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Only word-sized loads and stores are implemented
  localparam logic [2:0] F3_WORD = 3'b010;

  // Immediate format select
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Register-file write source select
  localparam logic [1:0] LD_ALU = 2'b00;
  localparam logic [1:0] LD_PC4 = 2'b01;
  localparam logic [1:0] LD_DM  = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_IALU,
    CLS_LW,
    CLS_SW,
    CLS_BRANCH,
    CLS_JAL,
    CLS_SYSTEM,
    CLS_ILLEGAL
  } instr_cls_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  // Map funct3 plus the alternate bit (funct7[5]) onto an ALU operation.
  // The caller decides whether the alternate bit is meaningful.
  function automatic alu_op_t alu_from_funct(input logic [2:0] funct3,
                                             input logic       alt);
    alu_op_t op;
    unique case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Branch outcome from the flags of rs1 - rs2; c=1 means rs1 >= rs2 unsigned.
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic       z,
                                        input logic       c,
                                        input logic       n);
    logic taken;
    unique case (funct3)
      3'b000:  taken = z;
      3'b001:  taken = !z;
      3'b100:  taken = n;
      3'b101:  taken = !n;
      3'b110:  taken = !c;
      3'b111:  taken = c;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/rv32i_decode.sv
// Combinational instruction decoder: classifies the instruction and derives
// the ALU operation and immediate format used while it executes.
module rv32i_decode
  import rv32i_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output instr_cls_t  cls,
  output alu_op_t     alu_op,
  output logic [1:0]  sel_imm,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7_b5 = instr[30];

  // Register indices and immediate bits are consumed by the datapath only
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // Classify on opcode, then validate funct3 where only a subset is legal
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    cls     = CLS_ILLEGAL;
    alu_op  = ALU_ADD;
    sel_imm = IMM_I;
    unique case (opcode)
      OP_R: begin
        cls    = CLS_R;
        alu_op = alu_from_funct(funct3, funct7_b5);
      end
      OP_IALU: begin
        // funct7[5] selects SRAI only; ADDI never becomes a subtract
        cls    = CLS_IALU;
        alu_op = alu_from_funct(funct3, funct7_b5 && (funct3 == 3'b101));
      end
      OP_LOAD: begin
        if (funct3 == F3_WORD) cls = CLS_LW;
      end
      OP_STORE: begin
        sel_imm = IMM_S;
        if (funct3 == F3_WORD) cls = CLS_SW;
      end
      OP_BRANCH: begin
        alu_op  = ALU_SUB;
        sel_imm = IMM_B;
        if (funct3 != 3'b010 && funct3 != 3'b011) cls = CLS_BRANCH;
      end
      OP_JAL: begin
        cls     = CLS_JAL;
        sel_imm = IMM_J;
      end
      OP_SYSTEM: cls = CLS_SYSTEM;
      default:   cls = CLS_ILLEGAL;
    endcase
  end

  assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives
// datapath enables and selects, and bounds data-memory waits with a timeout.
module rv32i_mc_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        z,
  input  logic        c,
  input  logic        n,
  input  logic        dm_ready,
  output logic        pc_en,
  output logic        ir_en,
  output logic        rf_wen,
  output logic        dm_wen,
  output logic        dm_req,
  output logic        sel_srcB,
  output logic [1:0]  sel_ld,
  output logic [1:0]  sel_imm,
  output logic        br_taken,
  output logic [3:0]  alu_op,
  output logic        retire,
  output logic        halted,
  output logic        fault
);

  // Last MEM wait count at which a missing dm_ready becomes a timeout
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       fault_q, fault_d;
  logic [7:0] wait_cnt;

  instr_cls_t dec_cls;
  alu_op_t    dec_alu_op;
  logic [1:0] dec_sel_imm;
  logic       dec_illegal;

  rv32i_decode u_decode (
    .instr   (instr),
    .cls     (dec_cls),
    .alu_op  (dec_alu_op),
    .sel_imm (dec_sel_imm),
    .illegal (dec_illegal)
  );

  // State and sticky fault flag
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q <= S_FETCH;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // MEM wait counter: zero outside MEM, counts MEM cycles, saturates at 255
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 8'd0;
    end else if (state_q != S_MEM) begin
      wait_cnt <= 8'd0;
    end else if (wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Next-state and output decode; everything is forced low while in reset
  always_comb begin
    state_d  = state_q;
    fault_d  = fault_q;
    pc_en    = 1'b0;
    ir_en    = 1'b0;
    rf_wen   = 1'b0;
    dm_wen   = 1'b0;
    dm_req   = 1'b0;
    sel_srcB = 1'b0;
    sel_ld   = LD_ALU;
    sel_imm  = IMM_I;
    br_taken = 1'b0;
    alu_op   = ALU_ADD;
    retire   = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;

    if (rst) begin
      fault = fault_q;

      // ALU selects stay stable from EXEC through MEM and WB
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
        alu_op   = dec_alu_op;
        sel_imm  = dec_sel_imm;
        sel_srcB = (dec_cls == CLS_IALU) || (dec_cls == CLS_LW) ||
                   (dec_cls == CLS_SW);
      end

      unique case (state_q)
        S_FETCH: begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end

        S_DECODE: begin
          if (dec_illegal) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else if (dec_cls == CLS_SYSTEM) begin
            state_d = S_HALT;
          end else begin
            state_d = S_EXEC;
          end
        end

        S_EXEC: begin
          unique case (dec_cls)
            CLS_R, CLS_IALU: state_d = S_WB;
            CLS_LW, CLS_SW:  state_d = S_MEM;
            CLS_BRANCH: begin
              br_taken = branch_taken(instr[14:12], z, c, n);
              pc_en    = 1'b1;
              retire   = 1'b1;
              state_d  = S_FETCH;
            end
            CLS_JAL: begin
              sel_ld   = LD_PC4;
              rf_wen   = 1'b1;
              br_taken = 1'b1;
              pc_en    = 1'b1;
              retire   = 1'b1;
              state_d  = S_FETCH;
            end
            default: begin
              // Unreachable: DECODE already diverted these classes to HALT
              fault_d = 1'b1;
              state_d = S_HALT;
            end
          endcase
        end

        S_MEM: begin
          dm_req = 1'b1;
          dm_wen = (dec_cls == CLS_SW);
          // A ready arriving on the last allowed cycle still completes
          if (dm_ready) begin
            if (dec_cls == CLS_SW) begin
              pc_en   = 1'b1;
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (wait_cnt >= WAIT_LAST) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end
        end

        S_WB: begin
          rf_wen  = 1'b1;
          sel_ld  = (dec_cls == CLS_LW) ? LD_DM : LD_ALU;
          pc_en   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end

        S_HALT: begin
          halted = 1'b1;
        end

        default: state_d = S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Directed bench for rv32i_mc_ctrl: per-cycle expected output bundles for
// ALU, branch, jump, load/store with waits, timeout, illegal and reset cases.
module tb_rv32i_mc_ctrl;
  import rv32i_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        z = 1'b0, c = 1'b0, n = 1'b0;
  logic        dm_ready = 1'b0;

  logic        pc_en, ir_en, rf_wen, dm_wen, dm_req, sel_srcB;
  logic [1:0]  sel_ld, sel_imm;
  logic        br_taken;
  logic [3:0]  alu_op;
  logic        retire, halted, fault;

  int checks = 0;
  int failures = 0;

  rv32i_mc_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .z        (z),
    .c        (c),
    .n        (n),
    .dm_ready (dm_ready),
    .pc_en    (pc_en),
    .ir_en    (ir_en),
    .rf_wen   (rf_wen),
    .dm_wen   (dm_wen),
    .dm_req   (dm_req),
    .sel_srcB (sel_srcB),
    .sel_ld   (sel_ld),
    .sel_imm  (sel_imm),
    .br_taken (br_taken),
    .alu_op   (alu_op),
    .retire   (retire),
    .halted   (halted),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  // Bundle: pc ir rf dwen dreq srcB ld[2] imm[2] br op[4] ret hlt flt
  logic [17:0] outs;
  assign outs = {pc_en, ir_en, rf_wen, dm_wen, dm_req, sel_srcB, sel_ld,
                 sel_imm, br_taken, alu_op, retire, halted, fault};

  localparam logic [17:0] E_FETCH = 18'h10000;
  localparam logic [17:0] E_ZERO  = 18'h00000;

  function automatic logic [17:0] ov(input logic pc, ir, rf, dw, dr, sb,
                                     input logic [1:0] ld, imm,
                                     input logic br,
                                     input logic [3:0] op,
                                     input logic ret, hlt, flt);
    return {pc, ir, rf, dw, dr, sb, ld, imm, br, op, ret, hlt, flt};
  endfunction

  // Hold reset for two edges, release just after a rising edge: cycle 1 follows
  task automatic do_reset(input logic [31:0] first_instr);
    rst      = 1'b0;
    instr    = first_instr;
    dm_ready = 1'b0;
    {z, c, n} = 3'b000;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    instr = 32'h002081B3;
    #1;
    checks++;
    if (outs !== E_ZERO) begin
      failures++;
      $display("FAIL reset_t0 outs=%h exp=%h", outs, E_ZERO);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (outs !== E_ZERO) begin
      failures++;
      $display("FAIL reset_held outs=%h exp=%h", outs, E_ZERO);
    end
  endtask

  task automatic test_add;
    logic [17:0] e [5];
    e = '{E_FETCH, E_ZERO, E_ZERO,
          ov(1,0,1,0,0,0,LD_ALU,IMM_I,0,ALU_ADD,1,0,0),
          E_FETCH};
    do_reset(32'h002081B3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== e[i]) begin
        failures++;
        $display("FAIL add cyc%0d outs=%h exp=%h", i + 1, outs, e[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // SUB, SRAI, ADDI-with-bit30 back to back; dm_ready held high throughout
  task automatic test_back_to_back;
    logic [31:0] prog [3];
    logic [17:0] e [13];
    prog = '{32'h402081B3, 32'h40315093, 32'h40508113};
    e = '{E_FETCH, E_ZERO,
          ov(0,0,0,0,0,0,LD_ALU,IMM_I,0,ALU_SUB,0,0,0),
          ov(1,0,1,0,0,0,LD_ALU,IMM_I,0,ALU_SUB,1,0,0),
          E_FETCH, E_ZERO,
          ov(0,0,0,0,0,1,LD_ALU,IMM_I,0,ALU_SRA,0,0,0),
          ov(1,0,1,0,0,1,LD_ALU,IMM_I,0,ALU_SRA,1,0,0),
          E_FETCH, E_ZERO,
          ov(0,0,0,0,0,1,LD_ALU,IMM_I,0,ALU_ADD,0,0,0),
          ov(1,0,1,0,0,1,LD_ALU,IMM_I,0,ALU_ADD,1,0,0),
          E_FETCH};
    do_reset(prog[0]);
    dm_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      instr = prog[(i / 4 > 2) ? 2 : i / 4];
      @(negedge clk);
      checks++;
      if (outs !== e[i]) begin
        failures++;
        $display("FAIL b2b cyc%0d outs=%h exp=%h", i + 1, outs, e[i]);
      end
      @(posedge clk);
      #1;
    end
    dm_ready = 1'b0;
  endtask

  // Branch outcomes for each flag sense, then JAL; 3 cycles each
  task automatic test_branch;
    logic [31:0] bi [7];
    logic [2:0]  bf [7];
    logic [17:0] be [7];
    bi = '{32'h00208063, 32'h00208063, 32'h0020E063, 32'h0020F063,
           32'h0020C063, 32'h00209063, 32'h008000EF};
    bf = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b001, 3'b100, 3'b000};
    be = '{ov(1,0,0,0,0,0,LD_ALU,IMM_B,1,ALU_SUB,1,0,0),
           ov(1,0,0,0,0,0,LD_ALU,IMM_B,0,ALU_SUB,1,0,0),
           ov(1,0,0,0,0,0,LD_ALU,IMM_B,1,ALU_SUB,1,0,0),
           ov(1,0,0,0,0,0,LD_ALU,IMM_B,0,ALU_SUB,1,0,0),
           ov(1,0,0,0,0,0,LD_ALU,IMM_B,1,ALU_SUB,1,0,0),
           ov(1,0,0,0,0,0,LD_ALU,IMM_B,0,ALU_SUB,1,0,0),
           ov(1,0,1,0,0,0,LD_PC4,IMM_J,1,ALU_ADD,1,0,0)};
    do_reset(bi[0]);
    for (int k = 0; k < 7; k++) begin
      instr = bi[k];
      {z, c, n} = bf[k];
      @(negedge clk);
      checks++;
      if (outs !== E_FETCH) begin
        failures++;
        $display("FAIL br%0d fetch outs=%h exp=%h", k, outs, E_FETCH);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (outs !== E_ZERO) begin
        failures++;
        $display("FAIL br%0d decode outs=%h exp=%h", k, outs, E_ZERO);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (outs !== be[k]) begin
        failures++;
        $display("FAIL br%0d exec outs=%h exp=%h", k, outs, be[k]);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++;
    if (outs !== E_FETCH) begin
      failures++;
      $display("FAIL br_end outs=%h exp=%h", outs, E_FETCH);
    end
    @(posedge clk);
    #1;
  endtask

  // LW with three wait cycles; ready is also pulsed outside MEM
  task automatic test_lw;
    logic        pr [9];
    logic [17:0] e [9];
    pr = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
    e = '{E_FETCH, E_ZERO,
          ov(0,0,0,0,0,1,LD_ALU,IMM_I,0,ALU_ADD,0,0,0),
          ov(0,0,0,0,1,1,LD_ALU,IMM_I,0,ALU_ADD,0,0,0),
          ov(0,0,0,0,1,1,LD_ALU,IMM_I,0,ALU_ADD,0,0,0),
          ov(0,0,0,0,1,1,LD_ALU,IMM_I,0,ALU_ADD,0,0,0),
          ov(0,0,0,0,1,1,LD_ALU,IMM_I,0,ALU_ADD,0,0,0),
          ov(1,0,1,0,0,1,LD_DM,IMM_I,0,ALU_ADD,1,0,0),
          E_FETCH};
    do_reset(32'h0080A183);
    for (int i = 0; i < 9; i++) begin
      dm_ready = pr[i];
      @(negedge clk);
      checks++;
      if (outs !== e[i]) begin
        failures++;
        $display("FAIL lw cyc%0d outs=%h exp=%h", i + 1, outs, e[i]);
      end
      @(posedge clk);
      #1;
    end
    dm_ready = 1'b0;
  endtask

  task automatic test_sw_ok;
    logic        pr [5];
    logic [17:0] e [5];
    pr = '{0, 0, 0, 1, 0};
    e = '{E_FETCH, E_ZERO,
          ov(0,0,0,0,0,1,LD_ALU,IMM_S,0,ALU_ADD,0,0,0),
          ov(1,0,0,1,1,1,LD_ALU,IMM_S,0,ALU_ADD,1,0,0),
          E_FETCH};
    do_reset(32'h0020A223);
    for (int i = 0; i < 5; i++) begin
      dm_ready = pr[i];
      @(negedge clk);
      checks++;
      if (outs !== e[i]) begin
        failures++;
        $display("FAIL sw cyc%0d outs=%h exp=%h", i + 1, outs, e[i]);
      end
      @(posedge clk);
      #1;
    end
    dm_ready = 1'b0;
  endtask

  // SW with no ready: four MEM cycles, then a faulted halt that persists
  task automatic test_sw_timeout;
    logic [17:0] e [9];
    e = '{E_FETCH, E_ZERO,
          ov(0,0,0,0,0,1,LD_ALU,IMM_S,0,ALU_ADD,0,0,0),
          ov(0,0,0,1,1,1,LD_ALU,IMM_S,0,ALU_ADD,0,0,0),
          ov(0,0,0,1,1,1,LD_ALU,IMM_S,0,ALU_ADD,0,0,0),
          ov(0,0,0,1,1,1,LD_ALU,IMM_S,0,ALU_ADD,0,0,0),
          ov(0,0,0,1,1,1,LD_ALU,IMM_S,0,ALU_ADD,0,0,0),
          18'h00003, 18'h00003};
    do_reset(32'h0020A223);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== e[i]) begin
        failures++;
        $display("FAIL sw_timeout cyc%0d outs=%h exp=%h", i + 1, outs, e[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Reset dropped between edges while an SW sits in MEM
  task automatic test_async_reset;
    logic [17:0] e_mem;
    logic [17:0] e [4];
    e_mem = ov(0,0,0,1,1,1,LD_ALU,IMM_S,0,ALU_ADD,0,0,0);
    e = '{E_FETCH, E_ZERO,
          ov(0,0,0,0,0,1,LD_ALU,IMM_S,0,ALU_ADD,0,0,0),
          ov(1,0,0,1,1,1,LD_ALU,IMM_S,0,ALU_ADD,1,0,0)};
    do_reset(32'h0020A223);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++;
    if (outs !== e_mem) begin
      failures++;
      $display("FAIL arst_in_mem outs=%h exp=%h", outs, e_mem);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (outs !== E_ZERO) begin
      failures++;
      $display("FAIL arst_drop outs=%h exp=%h", outs, E_ZERO);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dm_ready = (i == 3);
      @(negedge clk);
      checks++;
      if (outs !== e[i]) begin
        failures++;
        $display("FAIL arst_resume cyc%0d outs=%h exp=%h", i + 1, outs, e[i]);
      end
      @(posedge clk);
      #1;
    end
    dm_ready = 1'b0;
  endtask

  // LUI and LB are illegal (faulted halt); ECALL halts cleanly
  task automatic test_illegal;
    logic [31:0] il [3];
    logic [17:0] hv [3];
    il = '{32'h123450B7, 32'h00008183, 32'h00000073};
    hv = '{18'h00003, 18'h00003, 18'h00002};
    for (int k = 0; k < 3; k++) begin
      do_reset(il[k]);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checks++;
        if (outs !== ((i == 0) ? E_FETCH : (i == 1) ? E_ZERO : hv[k])) begin
          failures++;
          $display("FAIL halt%0d cyc%0d outs=%h exp=%h", k, i + 1, outs,
                   (i == 0) ? E_FETCH : (i == 1) ? E_ZERO : hv[k]);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_branch();
    test_lw();
    test_sw_ok();
    test_sw_timeout();
    test_async_reset();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
